// File: rtl/bk_mem_arbiter.sv
// Shared SRAM arbiter: alternates video word fetches and CPU accesses,
// with a level-handshaked CPU port held ready until strobes release.
module bk_mem_arbiter #(
  parameter int SRAM_WAIT = 2
) (
  input  logic        m_clock,
  input  logic        reset_n,
  input  logic        cpu_rd,
  input  logic        cpu_wt,
  input  logic        cpu_byte,
  input  logic [15:0] cpu_adr,
  input  logic [15:0] cpu_dout,
  output logic [15:0] cpu_din,
  output logic        cpu_rdy,
  input  logic        vid_req,
  input  logic [14:0] vid_adr,
  output logic [15:0] vid_data,
  output logic        vid_ack,
  output logic [14:0] sram_a,
  output logic [15:0] sram_d_o,
  output logic        sram_d_oe,
  input  logic [15:0] sram_d_i,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [2:0] {
    IDLE,
    VACC,
    CACC,
    VDONE,
    CDONE,
    CWAITREL
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'(SRAM_WAIT - 1);

  state_t     state;
  state_t     state_nx;
  logic       run;
  logic [2:0] cnt;
  logic       last_vid;
  logic       acc_wr;
  logic       acc_ub_n;
  logic       acc_lb_n;
  logic       cpu_rel;
  logic       cpu_pend;
  logic       acc_end;
  logic       in_acc;
  logic       grant_v;
  logic       grant_c;

  assign cpu_rel  = ~cpu_rd & ~cpu_wt;
  assign cpu_pend = ~cpu_rel & ~cpu_rdy & ~cpu_adr[15];
  assign acc_end  = (cnt == CNT_LAST);
  assign in_acc   = (state == VACC) || (state == CACC);

  always_ff @(posedge m_clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    grant_v  = 1'b0;
    grant_c  = 1'b0;
    unique case (state)
      IDLE: begin
        // run gates out the release edge so no access starts on it
        if (run) begin
          if (vid_req && !(cpu_pend && last_vid)) begin
            grant_v  = 1'b1;
            state_nx = VACC;
          end else if (cpu_pend) begin
            grant_c  = 1'b1;
            state_nx = CACC;
          end
        end
      end
      VACC: begin
        if (acc_end) state_nx = VDONE;
      end
      CACC: begin
        if (acc_end) state_nx = CDONE;
      end
      VDONE: begin
        state_nx = cpu_rdy ? CWAITREL : IDLE;
      end
      CDONE: begin
        state_nx = CWAITREL;
      end
      CWAITREL: begin
        if (cpu_rel) begin
          state_nx = IDLE;
        end else if (vid_req) begin
          grant_v  = 1'b1;
          state_nx = VACC;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge m_clock or negedge reset_n) begin
    if (!reset_n) begin
      run      <= 1'b0;
      cnt      <= 3'd0;
      last_vid <= 1'b0;
      acc_wr   <= 1'b0;
      acc_ub_n <= 1'b1;
      acc_lb_n <= 1'b1;
      sram_a   <= 15'd0;
      sram_d_o <= 16'd0;
      cpu_din  <= 16'd0;
      vid_data <= 16'd0;
      cpu_rdy  <= 1'b0;
    end else begin
      run <= 1'b1;
      if (grant_v || grant_c) begin
        cnt <= 3'd0;
      end else if (in_acc && !acc_end) begin
        cnt <= cnt + 3'd1;
      end
      if (grant_v) begin
        sram_a   <= vid_adr;
        acc_wr   <= 1'b0;
        acc_ub_n <= 1'b0;
        acc_lb_n <= 1'b0;
        last_vid <= 1'b1;
      end
      if (grant_c) begin
        sram_a   <= cpu_adr[15:1];
        acc_wr   <= cpu_wt;
        last_vid <= 1'b0;
        if (cpu_wt) begin
          sram_d_o <= cpu_dout;
          acc_ub_n <= cpu_byte & ~cpu_adr[0];
          acc_lb_n <= cpu_byte & cpu_adr[0];
        end else begin
          acc_ub_n <= 1'b0;
          acc_lb_n <= 1'b0;
        end
      end
      if (state == VACC && acc_end) begin
        vid_data <= sram_d_i;
      end
      if (state == CACC && acc_end) begin
        if (!acc_wr) cpu_din <= sram_d_i;
        cpu_rdy <= 1'b1;
      end
      if (state == CWAITREL && cpu_rel) begin
        cpu_rdy <= 1'b0;
      end
    end
  end

  // strobes decode straight from state so reset drops them at once
  assign sram_ce_n = ~in_acc;
  assign sram_oe_n = ~(in_acc & ~acc_wr);
  assign sram_we_n = ~(in_acc & acc_wr);
  assign sram_ub_n = in_acc ? acc_ub_n : 1'b1;
  assign sram_lb_n = in_acc ? acc_lb_n : 1'b1;
  assign sram_d_oe = acc_wr & (in_acc | (state == CDONE));
  assign vid_ack   = (state == VDONE);

endmodule
